ide_port_sequencer: RTL and testbench

//  Consumes the active-low I/O port chip select from the A500 RAM/AutoConfig CPLD and runs a

---
 rtl/ide_port_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_ide_port_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ide_port_sequencer.sv
// rtl/ide_port_sequencer.sv - timed IDE PIO register cycle behind one A500 I/O port chip select
//
// Ports:
//   CPU_CLK, RESET                      clock and synchronous active-high reset
//   IO_PORT_CS, CPU_AS, CPU_RW,
//   CPU_UDS, CPU_LDS, ADDRESS_LOW       68000-side request (A[4] picks CS1, A[3:1] the register)
//   IDE_DATA_IN, IDE_IORDY              drive-side read data and ready
//   IDE_CS0, IDE_CS1, IDE_A,
//   IDE_DIOR, IDE_DIOW                  IDE bus control (all registered)
//   BUF_OE, BUF_DIR                     data transceiver control
//   RD_DATA                             last captured read word
//   IO_ACK, IO_TIMEOUT                  cycle termination and IORDY timeout pulse
module ide_port_sequencer #(
    parameter int unsigned SETUP_CYCLES   = 2,
    parameter int unsigned PULSE_CYCLES   = 4,
    parameter int unsigned HOLD_CYCLES    = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CPU_CLK,
    input  logic        RESET,
    input  logic        IO_PORT_CS,
    input  logic        CPU_AS,
    input  logic        CPU_RW,
    input  logic        CPU_UDS,
    input  logic        CPU_LDS,
    input  logic [3:0]  ADDRESS_LOW,
    input  logic [15:0] IDE_DATA_IN,
    input  logic        IDE_IORDY,
    output logic        IDE_CS0,
    output logic        IDE_CS1,
    output logic [2:0]  IDE_A,
    output logic        IDE_DIOR,
    output logic        IDE_DIOW,
    output logic        BUF_OE,
    output logic        BUF_DIR,
    output logic [15:0] RD_DATA,
    output logic        IO_ACK,
    output logic        IO_TIMEOUT
);

    localparam logic [7:0] SETUP_L   = 8'(SETUP_CYCLES);
    localparam logic [7:0] PULSE_L   = 8'(PULSE_CYCLES);
    localparam logic [7:0] HOLD_L    = 8'(HOLD_CYCLES);
    localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_ACK} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  ext_q, ext_d;
    logic        armed_q, armed_d;
    logic        rd_q, rd_d;
    logic        abort_q, abort_d;
    logic        cs0_q, cs0_d, cs1_q, cs1_d;
    logic [2:0]  a_q, a_d;
    logic        dior_q, dior_d, diow_q, diow_d;
    logic        oe_q, oe_d, dir_q, dir_d;
    logic [15:0] rdata_q, rdata_d;
    logic        ack_q, ack_d, to_q, to_d;

    logic        start;
    logic [7:0]  cnt_inc, ext_inc;

    // Counters saturate rather than wrap.
    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign ext_inc = (ext_q == 8'hFF) ? ext_q : ext_q + 8'd1;

    // Only taken in IDLE so that a stray /AS low during HOLD cannot consume the arm.
    assign start = (state_q == S_IDLE) && !IO_PORT_CS && !CPU_AS &&
                   !(CPU_UDS && CPU_LDS) && armed_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ext_d   = ext_q;
        rd_d    = rd_q;
        abort_d = abort_q;
        cs0_d   = cs0_q;
        cs1_d   = cs1_q;
        a_d     = a_q;
        dior_d  = dior_q;
        diow_d  = diow_q;
        oe_d    = oe_q;
        dir_d   = dir_q;
        rdata_d = rdata_q;
        ack_d   = ack_q;
        to_d    = 1'b0;
        armed_d = start ? 1'b0 : (CPU_AS ? 1'b1 : armed_q);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = ADDRESS_LOW[2:0];
                    cs0_d   = ADDRESS_LOW[3];
                    cs1_d   = !ADDRESS_LOW[3];
                    rd_d    = CPU_RW;
                    dir_d   = CPU_RW;
                    oe_d    = 1'b0;
                    cnt_d   = 8'd0;
                    ext_d   = 8'd0;
                    abort_d = 1'b0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (CPU_AS) begin
                    abort_d = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = S_HOLD;
                end else if (cnt_q >= SETUP_L - 8'd1) begin
                    dior_d  = !rd_q;
                    diow_d  = rd_q;
                    cnt_d   = 8'd0;
                    state_d = S_STROBE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_STROBE: begin
                if (CPU_AS) begin
                    // Abort wins over a completion on the same edge; no capture.
                    dior_d  = 1'b1;
                    diow_d  = 1'b1;
                    abort_d = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = S_HOLD;
                end else if (cnt_q < PULSE_L - 8'd1) begin
                    cnt_d = cnt_inc;
                end else if (!IDE_IORDY && (ext_q < TIMEOUT_L)) begin
                    ext_d = ext_inc;
                end else begin
                    // Either IORDY released or the extra count ran out.
                    dior_d  = 1'b1;
                    diow_d  = 1'b1;
                    to_d    = !IDE_IORDY;
                    cnt_d   = 8'd0;
                    state_d = S_HOLD;
                    if (rd_q) begin
                        rdata_d = IDE_DATA_IN;
                    end
                end
            end
            S_HOLD: begin
                if (cnt_q >= HOLD_L - 8'd1) begin
                    cs0_d = 1'b1;
                    cs1_d = 1'b1;
                    cnt_d = 8'd0;
                    if (abort_q) begin
                        oe_d    = 1'b1;
                        dir_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ack_d   = 1'b0;
                        oe_d    = !rd_q;
                        state_d = S_ACK;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_ACK: begin
                if (CPU_AS) begin
                    ack_d   = 1'b1;
                    oe_d    = 1'b1;
                    dir_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CPU_CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            ext_q   <= 8'd0;
            armed_q <= 1'b0;
            rd_q    <= 1'b0;
            abort_q <= 1'b0;
            cs0_q   <= 1'b1;
            cs1_q   <= 1'b1;
            a_q     <= 3'd0;
            dior_q  <= 1'b1;
            diow_q  <= 1'b1;
            oe_q    <= 1'b1;
            dir_q   <= 1'b1;
            rdata_q <= 16'd0;
            ack_q   <= 1'b1;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ext_q   <= ext_d;
            armed_q <= armed_d;
            rd_q    <= rd_d;
            abort_q <= abort_d;
            cs0_q   <= cs0_d;
            cs1_q   <= cs1_d;
            a_q     <= a_d;
            dior_q  <= dior_d;
            diow_q  <= diow_d;
            oe_q    <= oe_d;
            dir_q   <= dir_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            to_q    <= to_d;
        end
    end

    assign IDE_CS0    = cs0_q;
    assign IDE_CS1    = cs1_q;
    assign IDE_A      = a_q;
    assign IDE_DIOR   = dior_q;
    assign IDE_DIOW   = diow_q;
    assign BUF_OE     = oe_q;
    assign BUF_DIR    = dir_q;
    assign RD_DATA    = rdata_q;
    assign IO_ACK     = ack_q;
    assign IO_TIMEOUT = to_q;

endmodule

// File: tb/tb_ide_port_sequencer.sv
// tb/tb_ide_port_sequencer.sv - self-checking bench for ide_port_sequencer
module tb_ide_port_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, cs_n, as_n, rw, uds_n, lds_n, iordy;
    logic [3:0]  addr;
    logic [15:0] din;

    logic        o_cs0 [2];
    logic        o_cs1 [2];
    logic [2:0]  o_a   [2];
    logic        o_dior[2];
    logic        o_diow[2];
    logic        o_oe  [2];
    logic        o_dir [2];
    logic [15:0] o_rd  [2];
    logic        o_ack [2];
    logic        o_to  [2];

    ide_port_sequencer u_dut0 (
        .CPU_CLK(clk), .RESET(rst), .IO_PORT_CS(cs_n), .CPU_AS(as_n), .CPU_RW(rw),
        .CPU_UDS(uds_n), .CPU_LDS(lds_n), .ADDRESS_LOW(addr), .IDE_DATA_IN(din), .IDE_IORDY(iordy),
        .IDE_CS0(o_cs0[0]), .IDE_CS1(o_cs1[0]), .IDE_A(o_a[0]), .IDE_DIOR(o_dior[0]),
        .IDE_DIOW(o_diow[0]), .BUF_OE(o_oe[0]), .BUF_DIR(o_dir[0]), .RD_DATA(o_rd[0]),
        .IO_ACK(o_ack[0]), .IO_TIMEOUT(o_to[0])
    );

    ide_port_sequencer #(.TIMEOUT_CYCLES(8)) u_dut1 (
        .CPU_CLK(clk), .RESET(rst), .IO_PORT_CS(cs_n), .CPU_AS(as_n), .CPU_RW(rw),
        .CPU_UDS(uds_n), .CPU_LDS(lds_n), .ADDRESS_LOW(addr), .IDE_DATA_IN(din), .IDE_IORDY(iordy),
        .IDE_CS0(o_cs0[1]), .IDE_CS1(o_cs1[1]), .IDE_A(o_a[1]), .IDE_DIOR(o_dior[1]),
        .IDE_DIOW(o_diow[1]), .BUF_OE(o_oe[1]), .BUF_DIR(o_dir[1]), .RD_DATA(o_rd[1]),
        .IO_ACK(o_ack[1]), .IO_TIMEOUT(o_to[1])
    );

    int n_total = 0;
    int n_pass  = 0;
    int tmo [2] = '{255, 8};
    logic [15:0] mrd [2] = '{16'h0, 16'h0};

    typedef struct {
        int          sel;
        logic        rd;
        logic [3:0]  a;
        logic [15:0] d;
        int          k;
        int          ab;
        int          len;
        logic        to;
        logic        ack;
        logic [15:0] rdv;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic check_reset(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s dut%0d", tag, i),
                  {5'd0, o_cs0[i], o_cs1[i], o_dior[i], o_diow[i], o_oe[i], o_ack[i], o_dir[i],
                   o_to[i], o_a[i], o_rd[i]},
                  {5'd0, 8'hFE, 3'b000, 16'h0000});
        end
    endtask

    function automatic int min_i(input int x, input int y);
        return (x < y) ? x : y;
    endfunction

    // The non-observed instance sees the same stimulus; the bench releases /AS two edges after the
    // observed instance exits its strobe, so the other one captures only if it exits strictly earlier.
    task automatic update_model(input int sel, input logic rd, input logic [15:0] d,
                                input int k, input int ab, input logic [15:0] rdv);
        int o;
        int rel;
        o = 1 - sel;
        mrd[sel] = rdv;
        rel = 6 + min_i(k, tmo[sel]) + 2;
        if (rd && ab == 0 && (6 + min_i(k, tmo[o])) < rel) mrd[o] = d;
    endtask

    // k: IORDY low cycles past the pulse minimum; ab: edge at which /AS is sampled high (0 = none).
    task automatic run_txn(input int sel, input logic rd, input logic [3:0] a, input logic [15:0] d,
                           input int k, input int ab, input int len, input logic to,
                           input logic ack, input logic [15:0] rdv, input string tag);
        int st_lo = 0, st_other = 0, st_first = -1, cs_lo = 0, cs_other = 0;
        int to_cnt = 0, ack_first = -1, bad = 0, e = 0, s;
        bit released = 0, done = 0;
        logic strobe_t, strobe_o, cs_t, cs_o;
        rw    = rd;
        addr  = a;
        din   = d;
        uds_n = 1'($urandom_range(0, 1));
        lds_n = uds_n ? 1'b0 : 1'($urandom_range(0, 1));
        iordy = 1'b0;
        cs_n  = 1'b0;
        as_n  = 1'b0;
        while (!done && e < 400) begin
            @(negedge clk);
            s = e;
            strobe_t = rd ? o_dior[sel] : o_diow[sel];
            strobe_o = rd ? o_diow[sel] : o_dior[sel];
            cs_t     = a[3] ? o_cs1[sel] : o_cs0[sel];
            cs_o     = a[3] ? o_cs0[sel] : o_cs1[sel];
            if (!strobe_t) begin
                st_lo++;
                if (st_first < 0) st_first = s;
                if (o_dir[sel] !== rd || o_oe[sel] !== 1'b0) bad++;
            end
            if (!strobe_o) st_other++;
            if (!cs_t) begin
                cs_lo++;
                if (o_a[sel] !== a[2:0]) bad++;
            end
            if (!cs_o) cs_other++;
            if (o_to[sel]) to_cnt++;
            if (!o_ack[sel] && ack_first < 0) ack_first = s;
            e++;
            iordy = (e >= 6 + k);
            if (ab > 0 && e == ab) as_n = 1'b1;
            if (ab > 0 && s >= ab + 1 && cs_t) done = 1;
            if (ack_first >= 0 && !released) begin
                released = 1;
                as_n = 1'b1;
            end else if (released && o_ack[sel]) begin
                done = 1;
            end
        end
        cs_n  = 1'b1;
        as_n  = 1'b1;
        iordy = 1'b1;
        repeat (3) @(negedge clk);
        check($sformatf("%s done", tag), 32'(done), 32'd1);
        check($sformatf("%s strobe_len", tag), st_lo, len);
        check($sformatf("%s exclusive", tag), st_other + cs_other, 0);
        if (len > 0) check($sformatf("%s strobe_start", tag), st_first, 2);
        check($sformatf("%s cs_len", tag), cs_lo, ack ? len + 3 : ab + 1);
        check($sformatf("%s addr_buf", tag), bad, 0);
        check($sformatf("%s timeout", tag), to_cnt, to ? 1 : 0);
        check($sformatf("%s ack_edge", tag), ack_first, ack ? len + 3 : -1);
        check($sformatf("%s rd_data", tag), o_rd[sel], rdv);
    endtask

    initial begin
        int nostart;
        int sel, k, ab, len;
        logic rd, to;
        logic [3:0] a;
        logic [15:0] d, ev;

        tbl[0] = '{0, 1'b1, 4'b0111, 16'h50A1, 0,  0, 4,  1'b0, 1'b1, 16'h50A1};
        tbl[1] = '{0, 1'b0, 4'b1110, 16'h1234, 0,  0, 4,  1'b0, 1'b1, 16'h50A1};
        tbl[2] = '{0, 1'b1, 4'b0011, 16'hC3C3, 10, 0, 14, 1'b0, 1'b1, 16'hC3C3};
        tbl[3] = '{1, 1'b1, 4'b0001, 16'hBEEF, 20, 0, 12, 1'b1, 1'b1, 16'hBEEF};
        tbl[4] = '{0, 1'b1, 4'b0101, 16'hDEAD, 0,  4, 2,  1'b0, 1'b0, 16'hC3C3};
        tbl[5] = '{1, 1'b0, 4'b1010, 16'h4321, 9,  0, 12, 1'b1, 1'b1, 16'hBEEF};
        tbl[6] = '{0, 1'b1, 4'b1000, 16'h0F0F, 8,  0, 12, 1'b0, 1'b1, 16'h0F0F};
        tbl[7] = '{1, 1'b1, 4'b0110, 16'hA5A5, 0,  2, 0,  1'b0, 1'b0, 16'h0F0F};
        tbl[8] = '{1, 1'b1, 4'b0010, 16'h7E57, 8,  0, 12, 1'b0, 1'b1, 16'h7E57};

        rst = 1'b1; cs_n = 1'b1; as_n = 1'b1; rw = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        addr = 4'd0; din = 16'd0; iordy = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("reset_state");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // No start without a data strobe, nor without the port select.
        nostart = 0;
        cs_n = 1'b0; as_n = 1'b0; uds_n = 1'b1; lds_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (!o_cs0[0] || !o_cs1[0]) nostart++;
        end
        cs_n = 1'b1; uds_n = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (!o_cs0[0] || !o_cs1[0]) nostart++;
        end
        check("no_start", nostart, 0);
        as_n = 1'b1; uds_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_txn(tbl[i].sel, tbl[i].rd, tbl[i].a, tbl[i].d, tbl[i].k, tbl[i].ab,
                    tbl[i].len, tbl[i].to, tbl[i].ack, tbl[i].rdv, $sformatf("vec%0d", i));
            update_model(tbl[i].sel, tbl[i].rd, tbl[i].d, tbl[i].k, tbl[i].ab, tbl[i].rdv);
        end

        // RESET pulsed while the read strobe is low.
        rw = 1'b1; addr = 4'b0000; din = 16'h1111; uds_n = 1'b0; lds_n = 1'b0;
        iordy = 1'b1; cs_n = 1'b0; as_n = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_strobe dior", 32'(o_dior[0]), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_reset("reset_in_strobe");
        rst = 1'b0; cs_n = 1'b1; as_n = 1'b1;
        repeat (3) @(negedge clk);
        mrd[0] = 16'h0;
        mrd[1] = 16'h0;
        run_txn(0, 1'b1, 4'b0100, 16'h2468, 0, 0, 4, 1'b0, 1'b1, 16'h2468, "post_reset");
        update_model(0, 1'b1, 16'h2468, 0, 0, 16'h2468);

        for (int i = 0; i < 30; i++) begin
            sel = int'($urandom_range(0, 1));
            rd  = 1'($urandom_range(0, 1));
            a   = 4'($urandom);
            d   = 16'($urandom);
            k   = int'($urandom_range(0, 12));
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
            len = (ab > 0) ? ((ab >= 3) ? ab - 2 : 0) : 4 + min_i(k, tmo[sel]);
            to  = (ab == 0) && (k > tmo[sel]);
            ev  = (rd && ab == 0) ? d : mrd[sel];
            run_txn(sel, rd, a, d, k, ab, len, to, (ab == 0), ev, $sformatf("rnd%0d", i));
            update_model(sel, rd, d, k, ab, ev);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
